// File: rtl/drbg_synchronisator.sv
// Keeps a local DRBG reseed counter aligned with a master's counter: catches up
// forward one reseed at a time, holds on a small lead, and restarts the DRBG on a large lead.
module drbg_synchronisator #(
    parameter int LARGE_GAP    = 16,
    parameter int RESYNC_PULSE = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        init_done,
    input  logic [31:0] sequence_internal,
    input  logic [31:0] sequence_external,
    input  logic        sequence_external_valid,
    input  logic        V,
    output logic        catch_up_mode,
    output logic        get_next_seed,
    output logic        reset_n_drbg,
    output logic        block_drbg_reseed
);

    typedef enum logic [2:0] {
        IDLE,
        CATCH_UP,
        WAIT_STEP,
        HOLD,
        RESYNC_RST,
        RESYNC_INIT
    } state_t;

    localparam logic [7:0]         PULSE_LAST = 8'(RESYNC_PULSE - 1);
    localparam logic signed [31:0] NEG_GAP    = 32'(-LARGE_GAP);

    state_t             state_reg, state_next, class_state;
    logic [31:0]        target_reg;
    logic [31:0]        latched_reg, latched_next;
    logic signed [31:0] d_signed;
    logic               eval_pending_reg, eval_consumed;
    logic               seed_req_next;
    logic [7:0]         pulse_cnt_reg;

    // Signed distance makes counter wraparound fall out naturally.
    always_comb begin
        d_signed = $signed(target_reg - sequence_internal);
        if (d_signed == 32'sd0) begin
            class_state = IDLE;
        end else if (d_signed > 32'sd0) begin
            class_state = CATCH_UP;
        end else if (d_signed >= NEG_GAP) begin
            class_state = HOLD;
        end else begin
            class_state = RESYNC_RST;
        end
    end

    // A pending strobe is acted on immediately only where no reseed or reset
    // is in flight; otherwise the wait states re-classify on exit with the latest target.
    always_comb begin
        state_next    = state_reg;
        seed_req_next = 1'b0;
        latched_next  = latched_reg;
        eval_consumed = 1'b0;
        case (state_reg)
            IDLE, HOLD: begin
                if (eval_pending_reg) begin
                    state_next    = class_state;
                    eval_consumed = 1'b1;
                end
            end
            CATCH_UP: begin
                eval_consumed = eval_pending_reg;
                if (eval_pending_reg && class_state != CATCH_UP) begin
                    state_next = class_state;
                end else if (init_done) begin
                    seed_req_next = 1'b1;
                    latched_next  = sequence_internal;
                    state_next    = WAIT_STEP;
                end
            end
            WAIT_STEP: begin
                if (sequence_internal != latched_reg && init_done) begin
                    state_next    = class_state;
                    eval_consumed = 1'b1;
                end
            end
            RESYNC_RST: begin
                if (pulse_cnt_reg == PULSE_LAST) begin
                    state_next = RESYNC_INIT;
                end
            end
            RESYNC_INIT: begin
                if (init_done) begin
                    state_next    = class_state;
                    eval_consumed = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= IDLE;
            target_reg        <= 32'd0;
            latched_reg       <= 32'd0;
            eval_pending_reg  <= 1'b0;
            pulse_cnt_reg     <= 8'd0;
            catch_up_mode     <= 1'b0;
            get_next_seed     <= 1'b0;
            block_drbg_reseed <= 1'b0;
            reset_n_drbg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            latched_reg <= latched_next;

            if (sequence_external_valid) begin
                target_reg       <= sequence_external - {31'd0, V};
                eval_pending_reg <= 1'b1;
            end else if (eval_consumed) begin
                eval_pending_reg <= 1'b0;
            end

            if (state_next == RESYNC_RST && state_reg != RESYNC_RST) begin
                pulse_cnt_reg <= 8'd0;
            end else if (state_reg == RESYNC_RST) begin
                pulse_cnt_reg <= pulse_cnt_reg + 8'd1;
            end

            // Outputs are decoded from the next state so they line up with state_reg.
            catch_up_mode     <= (state_next == CATCH_UP) || (state_next == WAIT_STEP);
            get_next_seed     <= seed_req_next;
            block_drbg_reseed <= (state_next == HOLD);
            reset_n_drbg      <= (state_next != RESYNC_RST);
        end
    end

endmodule

// File: tb/tb_drbg_synchronisator.sv
// Directed bench for drbg_synchronisator with a small behavioural DRBG counter model.
module tb_drbg_synchronisator;

    localparam int LARGE_GAP    = 16;
    localparam int RESYNC_PULSE = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        init_done = 1'b0;
    logic [31:0] sequence_internal;
    logic [31:0] sequence_external = 32'd0;
    logic        sequence_external_valid = 1'b0;
    logic        V = 1'b0;
    logic        catch_up_mode, get_next_seed, reset_n_drbg, block_drbg_reseed;

    // DRBG model controls
    logic [31:0] counter_q = 32'd0;
    int          busy_q = 0;
    int          init_cnt_q = 0;
    logic        local_req = 1'b0;
    logic        preload_en = 1'b0;
    logic [31:0] preload_val = 32'd0;

    // Monitors
    int   seed_cnt = 0, overshoot_cnt = 0, overlap_cnt = 0;
    int   low_run = 0, last_pulse = 0, resync_cnt = 0;
    logic prev_rst = 1'b0;

    int tests = 0;
    int fails = 0;

    assign sequence_internal = counter_q;

    drbg_synchronisator #(
        .LARGE_GAP   (LARGE_GAP),
        .RESYNC_PULSE(RESYNC_PULSE)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .init_done              (init_done),
        .sequence_internal      (sequence_internal),
        .sequence_external      (sequence_external),
        .sequence_external_valid(sequence_external_valid),
        .V                      (V),
        .catch_up_mode          (catch_up_mode),
        .get_next_seed          (get_next_seed),
        .reset_n_drbg           (reset_n_drbg),
        .block_drbg_reseed      (block_drbg_reseed)
    );

    always #5 clk = ~clk;

    // Reseed takes a few cycles; init_done is low while busy or initialising.
    always @(posedge clk) begin
        if (!reset_n_drbg) begin
            counter_q  <= 32'd0;
            init_done  <= 1'b0;
            init_cnt_q <= 4;
            busy_q     <= 0;
        end else if (preload_en) begin
            counter_q <= preload_val;
        end else if (!init_done) begin
            if (busy_q > 0) begin
                if (busy_q == 1) begin
                    counter_q <= counter_q + 32'd1;
                    init_done <= 1'b1;
                end
                busy_q <= busy_q - 1;
            end else if (init_cnt_q > 0) begin
                if (init_cnt_q == 1) init_done <= 1'b1;
                init_cnt_q <= init_cnt_q - 1;
            end
        end else if (get_next_seed || (local_req && !block_drbg_reseed)) begin
            init_done <= 1'b0;
            busy_q    <= 3;
        end
    end

    always @(posedge clk) begin
        prev_rst <= reset_n;
        if (get_next_seed) seed_cnt <= seed_cnt + 1;
        if (get_next_seed && (busy_q != 0 || !init_done)) overshoot_cnt <= overshoot_cnt + 1;
        if (get_next_seed && block_drbg_reseed) overlap_cnt <= overlap_cnt + 1;
        if (reset_n && prev_rst) begin
            if (!reset_n_drbg) begin
                low_run <= low_run + 1;
            end else if (low_run != 0) begin
                last_pulse <= low_run;
                resync_cnt <= resync_cnt + 1;
                low_run    <= 0;
            end
        end else begin
            low_run <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [31:0] ext, input logic v);
        sequence_external       = ext;
        V                       = v;
        sequence_external_valid = 1'b1;
        @(negedge clk);
        sequence_external_valid = 1'b0;
    endtask

    task automatic preload(input logic [31:0] val);
        @(negedge clk);
        preload_en  = 1'b1;
        preload_val = val;
        @(negedge clk);
        preload_en = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [31:0] start;
        logic [31:0] ext;
        logic        v;
        bit          toggle;
        int          cycles;
        logic [31:0] exp_int;
        logic        exp_block;
        int          exp_seeds;
        int          exp_resyncs;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int s0, r0;
        vecs[0] = '{"fwd_v1",       32'd10,         32'd20,  1'b1, 1'b0, 400, 32'd19, 1'b0, 9,  0};
        vecs[1] = '{"fwd_v0",       32'd19,         32'd29,  1'b0, 1'b0, 400, 32'd29, 1'b0, 10, 0};
        vecs[2] = '{"fwd_60",       32'd29,         32'd89,  1'b0, 1'b0, 800, 32'd89, 1'b0, 60, 0};
        vecs[3] = '{"hold_lead1",   32'd89,         32'd88,  1'b0, 1'b1, 500, 32'd89, 1'b1, 0,  0};
        vecs[4] = '{"resync_61",    32'd100,        32'd39,  1'b0, 1'b0, 800, 32'd39, 1'b0, 39, 1};
        vecs[5] = '{"equal",        32'd39,         32'd39,  1'b0, 1'b0, 100, 32'd39, 1'b0, 0,  0};
        vecs[6] = '{"wrap",         32'hFFFF_FFFE,  32'd3,   1'b0, 1'b0, 200, 32'd3,  1'b0, 5,  0};
        vecs[7] = '{"hold_gap16",   32'd40,         32'd24,  1'b0, 1'b0, 100, 32'd40, 1'b1, 0,  0};
        vecs[8] = '{"resync_gap17", 32'd40,         32'd23,  1'b0, 1'b0, 400, 32'd23, 1'b0, 23, 1};
        vecs[9] = '{"equal_v1",     32'd23,         32'd24,  1'b1, 1'b0, 100, 32'd23, 1'b0, 0,  0};

        // Reset values and reset_n_drbg release timing
        #2 reset_n = 1'b0;
        #1;
        check("rst_catch_up", {31'd0, catch_up_mode}, 32'd0);
        check("rst_get_seed", {31'd0, get_next_seed}, 32'd0);
        check("rst_block", {31'd0, block_drbg_reseed}, 32'd0);
        check("rst_drbg_n", {31'd0, reset_n_drbg}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1 check("rst_drbg_n_held", {31'd0, reset_n_drbg}, 32'd0);
        @(posedge clk);
        #1 check("rst_drbg_n_rise", {31'd0, reset_n_drbg}, 32'd1);
        s0 = seed_cnt;
        repeat (12) @(negedge clk);
        check("idle_no_seed", seed_cnt - s0, 32'd0);
        check("idle_catch_up", {31'd0, catch_up_mode}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            preload(vecs[i].start);
            s0 = seed_cnt;
            r0 = resync_cnt;
            strobe(vecs[i].ext, vecs[i].v);
            for (int c = 0; c < vecs[i].cycles; c++) begin
                local_req = vecs[i].toggle && (c >= 5) && (c % 2 == 1);
                @(negedge clk);
            end
            local_req = 1'b0;
            @(negedge clk);
            check({vecs[i].name, "_internal"}, sequence_internal, vecs[i].exp_int);
            check({vecs[i].name, "_block"}, {31'd0, block_drbg_reseed}, {31'd0, vecs[i].exp_block});
            check({vecs[i].name, "_catch_up"}, {31'd0, catch_up_mode}, 32'd0);
            check({vecs[i].name, "_drbg_n"}, {31'd0, reset_n_drbg}, 32'd1);
            check({vecs[i].name, "_seeds"}, seed_cnt - s0, vecs[i].exp_seeds);
            check({vecs[i].name, "_resyncs"}, resync_cnt - r0, vecs[i].exp_resyncs);
            if (vecs[i].exp_resyncs != 0)
                check({vecs[i].name, "_pulse"}, last_pulse, RESYNC_PULSE);
            $display("[TB] vector %s ext=%0d V=%0d internal=%0d", vecs[i].name,
                     vecs[i].ext, vecs[i].v, sequence_internal);
        end

        // Hold then release: block drops within two cycles of the strobe
        preload(32'd50);
        strobe(32'd49, 1'b0);
        repeat (20) @(negedge clk);
        check("rel_block_on", {31'd0, block_drbg_reseed}, 32'd1);
        strobe(32'd50, 1'b0);
        @(negedge clk);
        check("rel_block_2cyc", {31'd0, block_drbg_reseed}, 32'd0);
        repeat (150) @(negedge clk);
        check("rel_internal", sequence_internal, 32'd50);
        $display("[TB] release sequence internal=%0d", sequence_internal);

        // Reset asserted while catching up
        strobe(32'd70, 1'b0);
        for (int c = 0; c < 10 && !catch_up_mode; c++) @(negedge clk);
        check("mid_cu_entered", {31'd0, catch_up_mode}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_catch_up", {31'd0, catch_up_mode}, 32'd0);
        check("mid_rst_get_seed", {31'd0, get_next_seed}, 32'd0);
        check("mid_rst_block", {31'd0, block_drbg_reseed}, 32'd0);
        check("mid_rst_drbg_n", {31'd0, reset_n_drbg}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        s0 = seed_cnt;
        repeat (20) @(negedge clk);
        check("post_rst_no_seed", seed_cnt - s0, 32'd0);
        check("post_rst_drbg_n", {31'd0, reset_n_drbg}, 32'd1);
        $display("[TB] mid-operation reset sequence done");

        check("no_overshoot", overshoot_cnt, 32'd0);
        check("no_block_seed_overlap", overlap_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/drbg_synchronisator.md
DRBG_SYNCHRONISATOR -- requirements
Module: drbg_synchronisator

Interface
REQ-001 Parameter: LARGE_GAP, default 16, max amount internal may lead external and still be handled by holding rather than a DRBG restart.
REQ-002 Parameter: RESYNC_PULSE, default 2, width in clk cycles of the DRBG reset pulse.
REQ-003 Port: clk, input, 1, single clock; all logic on rising edge.
REQ-004 Port: reset_n, input, 1, reset; asynchronous, active-low.
REQ-005 Port: init_done, input, 1, DRBG instantiate/reseed-ready flag.
REQ-006 Port: sequence_internal, input, 32, local DRBG reseed counter, low 32 bits.
REQ-007 Port: sequence_external, input, 32, counter value received from the master.
REQ-008 Port: sequence_external_valid, input, 1, one-cycle strobe qualifying sequence_external and V.
REQ-009 Port: V, input, 1, offset flag; 1 = the external value is one ahead of the target.
REQ-010 Port: catch_up_mode, output, 1, tells the DRBG to reseed without producing output bits.
REQ-011 Port: get_next_seed, output, 1, one-cycle reseed request to the DRBG.
REQ-012 Port: reset_n_drbg, output, 1, active-low reset for the DRBG.
REQ-013 Port: block_drbg_reseed, output, 1, suppresses all DRBG reseed requests, local and external.

Function
REQ-014 On a valid strobe, capture target = sequence_external - V (32-bit modular) and recompute d = target - sequence_internal as 32-bit two's complement.
REQ-015 A new strobe in any state overrides the previous target; the latest strobe wins, re-evaluated the next cycle.
REQ-016 States: IDLE, CATCH_UP, WAIT_STEP, HOLD, RESYNC_RST, RESYNC_INIT.
REQ-017 d == 0 -> IDLE; all outputs inactive; reset_n_drbg = 1.
REQ-018 d > 0 -> CATCH_UP with catch_up_mode = 1.
REQ-019 CATCH_UP: when init_done = 1, pulse get_next_seed for exactly one cycle, latch sequence_internal, then enter WAIT_STEP.
REQ-020 WAIT_STEP: stay until sequence_internal differs from the latched value and init_done = 1.
REQ-021 WAIT_STEP exit: if sequence_internal == target, go to IDLE and drop catch_up_mode; otherwise return to CATCH_UP.
REQ-022 Never overshoot: at most one outstanding get_next_seed.
REQ-023 -LARGE_GAP <= d < 0 -> HOLD with block_drbg_reseed = 1; hold until a new strobe gives d >= 0.
REQ-024 d < -LARGE_GAP -> RESYNC_RST: drive reset_n_drbg = 0 for RESYNC_PULSE cycles.
REQ-025 After RESYNC_RST, enter RESYNC_INIT; wait for init_done = 1, then re-evaluate d.
REQ-026 The re-evaluation after RESYNC_INIT is normally d > 0, leading to CATCH_UP.
REQ-027 The wraparound case is covered by the signed interpretation of d.
REQ-028 All outputs are registered.
REQ-029 block_drbg_reseed and get_next_seed are never both 1.
REQ-030 catch_up_mode = 1 only in CATCH_UP and WAIT_STEP.

Reset
REQ-031 While reset_n = 0, with asynchronous assertion: state = IDLE, catch_up_mode = 0, get_next_seed = 0, block_drbg_reseed = 0, reset_n_drbg = 0, target = 0.
REQ-032 reset_n_drbg rises one cycle after reset_n deasserts.
REQ-033 After reset, no action until the first valid strobe.

Verification
REQ-034 Forward catch-up: internal = 10, strobe ext = 20, V = 1 -> catch_up_mode = 1 and repeated get_next_seed pulses; settle at internal = 19, then IDLE with catch_up_mode = 0.
REQ-035 Forward catch-up, no offset: internal = 19, strobe ext = 29, V = 0 -> internal stops at exactly 29.
REQ-036 Larger forward gap: strobe ext = internal + 60 -> internal reaches ext with no overshoot.
REQ-037 Small lead: strobe ext = internal - 1, local reseed requests toggled for 500 cycles -> block_drbg_reseed = 1 and internal unchanged.
REQ-038 Small lead release: then strobe ext = internal -> block_drbg_reseed = 0 within 2 cycles; internal equals ext 150 cycles later.
REQ-039 Large lead: strobe ext = internal - 61 -> reset_n_drbg low for RESYNC_PULSE cycles, DRBG reinitialises, catch-up to ext, then IDLE.
REQ-040 Equal value and reset mid-operation: strobe ext = internal -> no get_next_seed or block.
REQ-041 Asserting reset_n low during CATCH_UP -> all outputs return to reset values immediately.
